// File: rtl/ins_decode_buffer_pkg.sv
// Shared decode definitions: opcode classes, RV32I major opcodes and the
// buffered entry layout used by the instruction decode buffer.
package decode_pkg;

  localparam int XLEN  = 32;
  localparam int PCLEN = 32;

  typedef enum logic [3:0] {
    OPCLS_NONE   = 4'd0,
    OPCLS_LUI    = 4'd1,
    OPCLS_AUIPC  = 4'd2,
    OPCLS_JAL    = 4'd3,
    OPCLS_JALR   = 4'd4,
    OPCLS_BRANCH = 4'd5,
    OPCLS_LOAD   = 4'd6,
    OPCLS_STORE  = 4'd7,
    OPCLS_OPIMM  = 4'd8,
    OPCLS_OP     = 4'd9
  } opcls_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [PCLEN-1:0] pc;
    logic [XLEN-1:0]  ins;
    opcls_e           opcls;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } entry_t;

  // 12-bit immediates (I and S formats) sign-extended to the datapath width
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/ins_decode_buffer_if.sv
// Fetch-side and issue-side handshakes of the decode buffer bundled together.
// master = fetch/issue environment, slave = the buffer itself.
interface ins_decode_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_ins;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_ready;

  logic                  dec_valid;
  logic                  dec_ready;
  logic [ADDR_WIDTH-1:0] dec_pc;
  logic [DATA_WIDTH-1:0] dec_ins;
  logic [3:0]            dec_opcls;
  logic [4:0]            dec_rd;
  logic [4:0]            dec_rs1;
  logic [4:0]            dec_rs2;
  logic [2:0]            dec_funct3;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_illegal;

  modport master (
    output if_valid, if_ins, if_pc, dec_ready,
    input  if_ready, dec_valid, dec_pc, dec_ins, dec_opcls, dec_rd, dec_rs1,
           dec_rs2, dec_funct3, dec_imm, dec_illegal
  );

  modport slave (
    input  if_valid, if_ins, if_pc, dec_ready,
    output if_ready, dec_valid, dec_pc, dec_ins, dec_opcls, dec_rd, dec_rs1,
           dec_rs2, dec_funct3, dec_imm, dec_illegal
  );

endinterface

// File: rtl/ins_decode_buffer_core.sv
// Purely combinational RV32I pre-decode: opcode class, sign-extended
// immediate and illegal flag for one raw instruction.
module ins_decode_core
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] ins,
  output opcls_e          opcls,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  always_comb begin
    opcls   = OPCLS_NONE;
    imm     = '0;
    illegal = 1'b0;
    case (ins[6:0])
      OPC_LUI: begin
        opcls = OPCLS_LUI;
        imm   = {ins[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        opcls = OPCLS_AUIPC;
        imm   = {ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        opcls = OPCLS_JAL;
        imm   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        opcls = OPCLS_JALR;
        imm   = sext12(ins[31:20]);
      end
      OPC_BRANCH: begin
        opcls = OPCLS_BRANCH;
        imm   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_LOAD: begin
        opcls = OPCLS_LOAD;
        imm   = sext12(ins[31:20]);
      end
      OPC_STORE: begin
        opcls = OPCLS_STORE;
        imm   = sext12({ins[31:25], ins[11:7]});
      end
      OPC_OPIMM: begin
        opcls = OPCLS_OPIMM;
        imm   = sext12(ins[31:20]);
      end
      OPC_OP: begin
        opcls = OPCLS_OP;
      end
      // Unknown opcodes are still buffered; issue turns the flag into a trap
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ins_decode_buffer.sv
// Two-entry decode FIFO between fetch and issue. Instructions are decoded as
// they enter, so issue sees fully decoded fields straight from the head entry.
module ins_decode_buffer
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = PCLEN
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  ins_decode_buffer_if.slave  bus
);

  localparam int         DEPTH = 2;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] count_reg, count_next;
  logic       head_reg, head_next;
  logic       tail_reg, tail_next;

  entry_t     entry_reg [DEPTH];
  entry_t     new_entry;
  entry_t     head_entry;
  logic [DEPTH-1:0] wr_en;

  opcls_e          new_opcls;
  logic [XLEN-1:0] new_imm;
  logic            new_illegal;

  logic enq;
  logic deq;

  ins_decode_core u_core (
    .ins     (XLEN'(bus.if_ins)),
    .opcls   (new_opcls),
    .imm     (new_imm),
    .illegal (new_illegal)
  );

  assign new_entry = '{
    pc:      PCLEN'(bus.if_pc),
    ins:     XLEN'(bus.if_ins),
    opcls:   new_opcls,
    imm:     new_imm,
    illegal: new_illegal
  };

  // Ready depends only on registered count and global controls, never on if_valid
  assign bus.if_ready  = (count_reg != FULL) && rdy_in && !flush_in && !rst_in;
  assign bus.dec_valid = (count_reg != 2'd0) && rdy_in;

  assign enq = bus.if_valid && bus.if_ready;
  assign deq = bus.dec_valid && bus.dec_ready && !flush_in;

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush_in) begin
      count_next = 2'd0;
      head_next  = 1'b0;
      tail_next  = 1'b0;
    end else begin
      if (enq) tail_next = ~tail_reg;
      if (deq) head_next = ~head_reg;
      case ({enq, deq})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = enq && (tail_reg == 1'(gi));
    end
  endgenerate

  // Storage is cleared by reset so the head payload is never X
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) entry_reg[i] <= new_entry;
      end
    end
  end

  assign head_entry = entry_reg[head_reg];

  assign bus.dec_pc      = ADDR_WIDTH'(head_entry.pc);
  assign bus.dec_ins     = DATA_WIDTH'(head_entry.ins);
  assign bus.dec_opcls   = head_entry.opcls;
  assign bus.dec_rd      = head_entry.ins[11:7];
  assign bus.dec_rs1     = head_entry.ins[19:15];
  assign bus.dec_rs2     = head_entry.ins[24:20];
  assign bus.dec_funct3  = head_entry.ins[14:12];
  assign bus.dec_imm     = DATA_WIDTH'(head_entry.imm);
  assign bus.dec_illegal = head_entry.illegal;

endmodule

// File: tb/tb_ins_decode_buffer.sv
// Directed bench for the decode buffer: decode fields, back-pressure,
// streaming, flush, run-enable hold and asynchronous reset.
module tb_ins_decode_buffer;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush_in;

  int checks = 0;
  int errors = 0;

  ins_decode_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  ins_decode_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // decode table: ins, opcls, imm, illegal, rd, rs1, rs2, funct3
  logic [31:0] tv_ins   [5] = '{32'h123450B7, 32'hFE000EE3, 32'hFE112E23, 32'h0000007F, 32'h008000EF};
  logic [3:0]  tv_opcls [5] = '{4'd1, 4'd5, 4'd7, 4'd0, 4'd3};
  logic [31:0] tv_imm   [5] = '{32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0, 32'h8};
  logic        tv_ill   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [4:0]  tv_rd    [5] = '{5'd1, 5'd29, 5'd28, 5'd0, 5'd1};
  logic [4:0]  tv_rs1   [5] = '{5'd8, 5'd0, 5'd2, 5'd0, 5'd0};
  logic [4:0]  tv_rs2   [5] = '{5'd3, 5'd0, 5'd1, 5'd0, 5'd8};
  logic [2:0]  tv_f3    [5] = '{3'd5, 3'd0, 3'd2, 3'd0, 3'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] ins);
    bus.if_pc    = pc;
    bus.if_ins   = ins;
    bus.if_valid = 1'b1;
    tick();
    bus.if_valid = 1'b0;
    #1;
  endtask

  task automatic pop();
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    flush_in      = 1'b0;
    bus.if_valid  = 1'b0;
    bus.if_ins    = '0;
    bus.if_pc     = '0;
    bus.dec_ready = 1'b0;

    // reset state
    #3;
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_dec_pc", bus.dec_pc, 0);
    chk("rst_dec_ins", bus.dec_ins, 0);
    chk("rst_dec_imm", bus.dec_imm, 0);
    chk("rst_dec_illegal", bus.dec_illegal, 0);
    #9;
    rst_in = 1'b0;
    #1;
    chk("post_rst_if_ready", bus.if_ready, 1);
    $display("txn reset released");

    // addi x1,x0,-1
    enq(32'h100, 32'hFFF00093);
    chk("addi_valid", bus.dec_valid, 1);
    chk("addi_opcls", bus.dec_opcls, 8);
    chk("addi_rd", bus.dec_rd, 1);
    chk("addi_rs1", bus.dec_rs1, 0);
    chk("addi_imm", bus.dec_imm, 32'hFFFFFFFF);
    chk("addi_illegal", bus.dec_illegal, 0);
    chk("addi_pc", bus.dec_pc, 32'h100);
    $display("txn addi pc=%0h imm=%0h", bus.dec_pc, bus.dec_imm);
    pop();
    chk("addi_popped", bus.dec_valid, 0);

    // decode coverage
    for (int i = 0; i < 5; i++) begin
      enq(32'h180 + 32'(4 * i), tv_ins[i]);
      chk("dec_valid", bus.dec_valid, 1);
      chk("dec_ins", bus.dec_ins, tv_ins[i]);
      chk("dec_opcls", bus.dec_opcls, tv_opcls[i]);
      chk("dec_imm", bus.dec_imm, tv_imm[i]);
      chk("dec_illegal", bus.dec_illegal, tv_ill[i]);
      chk("dec_rd", bus.dec_rd, tv_rd[i]);
      chk("dec_rs1", bus.dec_rs1, tv_rs1[i]);
      chk("dec_rs2", bus.dec_rs2, tv_rs2[i]);
      chk("dec_funct3", bus.dec_funct3, tv_f3[i]);
      $display("txn decode ins=%08h opcls=%0d imm=%08h illegal=%0b",
               bus.dec_ins, bus.dec_opcls, bus.dec_imm, bus.dec_illegal);
      pop();
    end

    // back-pressure: A and B fill the buffer, C waits on the fetch side
    enq(32'h200, 32'h00100093);
    enq(32'h204, 32'h00200113);
    bus.if_pc    = 32'h208;
    bus.if_ins   = 32'h00300193;
    bus.if_valid = 1'b1;
    #1;
    chk("bp_full_ready", bus.if_ready, 0);
    tick();
    chk("bp_held_ready", bus.if_ready, 0);
    chk("bp_head_a", bus.dec_pc, 32'h200);
    bus.dec_ready = 1'b1;
    tick();
    chk("bp_pop_a_ready", bus.if_ready, 1);
    chk("bp_head_b", bus.dec_pc, 32'h204);
    $display("txn bp pop A, head=%0h", bus.dec_pc);
    tick();
    bus.if_valid = 1'b0;
    #1;
    chk("bp_head_c_valid", bus.dec_valid, 1);
    chk("bp_head_c", bus.dec_pc, 32'h208);
    $display("txn bp pop B, head=%0h", bus.dec_pc);
    tick();
    chk("bp_empty", bus.dec_valid, 0);
    $display("txn bp pop C");
    bus.dec_ready = 1'b0;

    // streaming
    bus.dec_ready = 1'b1;
    bus.if_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.if_pc  = 32'h300 + 32'(4 * i);
      bus.if_ins = 32'h00000013;
      tick();
      chk("stream_valid", bus.dec_valid, 1);
      chk("stream_pc", bus.dec_pc, 32'h300 + 32'(4 * i));
      chk("stream_count", dut.count_reg, 1);
      chk("stream_ready", bus.if_ready, 1);
      $display("txn stream pc=%0h", bus.dec_pc);
    end
    bus.if_valid = 1'b0;
    tick();
    chk("stream_drain", bus.dec_valid, 0);
    bus.dec_ready = 1'b0;

    // flush with buffer full and an offered instruction
    enq(32'h400, 32'h00000013);
    enq(32'h404, 32'h00000013);
    bus.if_pc    = 32'h408;
    bus.if_valid = 1'b1;
    flush_in     = 1'b1;
    #1;
    chk("flush_if_ready", bus.if_ready, 0);
    tick();
    flush_in     = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    chk("flush_full_valid", bus.dec_valid, 0);
    chk("flush_full_count", dut.count_reg, 0);
    $display("txn flush full");

    // flush with one entry and a same-cycle offer that must be dropped
    enq(32'h410, 32'h00000013);
    bus.if_pc    = 32'h414;
    bus.if_valid = 1'b1;
    flush_in     = 1'b1;
    tick();
    flush_in     = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    chk("flush_one_valid", bus.dec_valid, 0);
    chk("flush_one_count", dut.count_reg, 0);
    enq(32'h500, 32'h00000013);
    chk("post_flush_pc", bus.dec_pc, 32'h500);
    chk("post_flush_count", dut.count_reg, 1);
    $display("txn flush one, next head=%0h", bus.dec_pc);

    // run enable low holds everything
    rdy_in        = 1'b0;
    bus.dec_ready = 1'b1;
    bus.if_pc     = 32'h504;
    bus.if_valid  = 1'b1;
    #1;
    chk("hold_dec_valid", bus.dec_valid, 0);
    chk("hold_if_ready", bus.if_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_count", dut.count_reg, 1);
    end
    bus.if_valid  = 1'b0;
    bus.dec_ready = 1'b0;
    rdy_in        = 1'b1;
    #1;
    chk("hold_return_valid", bus.dec_valid, 1);
    chk("hold_return_pc", bus.dec_pc, 32'h500);
    $display("txn rdy hold, head=%0h", bus.dec_pc);
    pop();

    // asynchronous reset between edges with the buffer full
    enq(32'h600, 32'h00000013);
    enq(32'h604, 32'h00000013);
    chk("pre_arst_count", dut.count_reg, 2);
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst_dec_valid", bus.dec_valid, 0);
    chk("arst_if_ready", bus.if_ready, 0);
    chk("arst_dec_pc", bus.dec_pc, 0);
    chk("arst_count", dut.count_reg, 0);
    $display("txn async reset");
    tick();
    rst_in = 1'b0;
    #1;
    chk("arst_release_ready", bus.if_ready, 1);
    chk("arst_release_valid", bus.dec_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
